// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
// Optional abort support is enabled by defining SYSTOLIC_CTRL_ABORT_EN.
package systolic_pkg;

    localparam int unsigned DefN  = 4;
    localparam int unsigned DefDw = 8;
    localparam int unsigned DefKw = 8;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StDone,
        StAbort
    } state_e;

    // 1 read-latency cycle + 2(N-1) skew/propagation + product, accumulate and C_out stages
    function automatic int unsigned drain_cyc(input int unsigned n);
        return 2 * n + 2;
    endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Command, operand-buffer and array-side signals of the systolic sequencer.
// slave: the sequencer's view; master: the host/buffer/array environment.
interface systolic_ctrl_if #(
    parameter int unsigned N  = systolic_pkg::DefN,
    parameter int unsigned DW = systolic_pkg::DefDw,
    parameter int unsigned KW = systolic_pkg::DefKw
);

    logic            start;
    logic [KW-1:0]   k_len;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [KW-1:0]   rd_addr;
    logic [N*DW-1:0] a_rd_data;
    logic [N*DW-1:0] b_rd_data;
    logic [N*DW-1:0] a_feed;
    logic [N*DW-1:0] b_feed;
    logic            pe_en;
    logic            pe_rst_n;

    modport slave (
        input  start, k_len, a_rd_data, b_rd_data,
        output busy, done, rd_en, rd_addr, a_feed, b_feed, pe_en, pe_rst_n
    );

    modport master (
        output start, k_len, a_rd_data, b_rd_data,
        input  busy, done, rd_en, rd_addr, a_feed, b_feed, pe_en, pe_rst_n
    );

endinterface

// File: rtl/skew_line.sv
// Fixed-length delay line for one operand lane; pass-through when DELAY is 0.
module skew_line #(
    parameter int unsigned DELAY = 1,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    if (DELAY == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst_n, clr};
        assign dout = din;
    end else begin : g_delay
        logic [DW-1:0] stage_q [DELAY];

        // Shift chain; reset and clear both flush every stage to zero
        always_ff @(posedge clk) begin
            if (!rst_n || clr) begin
                for (int unsigned s = 0; s < DELAY; s++) begin
                    stage_q[s] <= '0;
                end
            end else begin
                stage_q[0] <= din;
                for (int unsigned s = 1; s < DELAY; s++) begin
                    stage_q[s] <= stage_q[s-1];
                end
            end
        end

        assign dout = stage_q[DELAY-1];
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN output-stationary systolic MAC array: clears the array,
// streams k_len operand vectors with diagonal skew, drains, then pulses done.
// Define SYSTOLIC_CTRL_ABORT_EN to add the abort input and ABORT state.
module systolic_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned N  = DefN,
    parameter int unsigned DW = DefDw,
    parameter int unsigned KW = DefKw
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SYSTOLIC_CTRL_ABORT_EN
    input  logic abort,
`endif
    systolic_ctrl_if.slave bus
);

    localparam int unsigned DrainCyc = drain_cyc(N);
    localparam int unsigned DcW      = $clog2(DrainCyc);

    state_e         state_q, state_d;
    logic [KW-1:0]  k_len_q, k_len_d;
    logic [KW-1:0]  k_cnt_q, k_cnt_d;
    logic [DcW-1:0] drain_cnt_q, drain_cnt_d;
    logic           init_q;
    logic           valid_q;
    logic           skew_clr;

    logic           busy;
    logic           done;
    logic           rd_en;
    logic [KW-1:0]  rd_addr;
    logic           pe_en;
    logic           pe_rst_n;
    logic [N*DW-1:0] a_feed;
    logic [N*DW-1:0] b_feed;

    // State, counters and the post-reset flag that releases the array reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            k_len_q     <= '0;
            k_cnt_q     <= '0;
            drain_cnt_q <= '0;
            init_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_len_q     <= k_len_d;
            k_cnt_q     <= k_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            init_q      <= 1'b1;
        end
    end

    // Next-state logic; FEED stops at k_len-1 so the KW-bit counter never wraps
    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        k_cnt_d     = k_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.start && (bus.k_len != '0)) begin
                    k_len_d = bus.k_len;
                    state_d = StClear;
                end
            end
            StClear: begin
                k_cnt_d = '0;
                state_d = StFeed;
            end
            StFeed: begin
                if (k_cnt_q == k_len_q - 1'b1) begin
                    k_cnt_d     = '0;
                    drain_cnt_d = '0;
                    state_d     = StDrain;
                end else begin
                    k_cnt_d = k_cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_cnt_q == DcW'(DrainCyc - 1)) begin
                    state_d = StDone;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
`ifdef SYSTOLIC_CTRL_ABORT_EN
        if (abort && (state_q inside {StClear, StFeed, StDrain})) begin
            state_d = StAbort;
        end
`endif
    end

    // Moore outputs decoded from the current state
    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        rd_en    = (state_q == StFeed);
        rd_addr  = rd_en ? k_cnt_q : '0;
        pe_en    = (state_q == StFeed) || (state_q == StDrain);
        pe_rst_n = init_q && !(state_q inside {StClear, StAbort});
    end

`ifdef SYSTOLIC_CTRL_ABORT_EN
    // Flush in-flight operands on the edge into ABORT so that cycle already feeds zeros
    assign skew_clr = (state_d == StAbort);
`else
    assign skew_clr = 1'b0;
`endif

    // Buffer data arrives one cycle after rd_en; this bit marks it valid
    always_ff @(posedge clk) begin
        if (!rst_n || skew_clr) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(
            .DELAY(i),
            .DW   (DW)
        ) u_a_skew (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (skew_clr),
            .din  (bus.a_rd_data[i*DW +: DW] & {DW{valid_q}}),
            .dout (a_feed[i*DW +: DW])
        );

        skew_line #(
            .DELAY(i),
            .DW   (DW)
        ) u_b_skew (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (skew_clr),
            .din  (bus.b_rd_data[i*DW +: DW] & {DW{valid_q}}),
            .dout (b_feed[i*DW +: DW])
        );
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.rd_en    = rd_en;
    assign bus.rd_addr  = rd_addr;
    assign bus.pe_en    = pe_en;
    assign bus.pe_rst_n = pe_rst_n;
    assign bus.a_feed   = a_feed;
    assign bus.b_feed   = b_feed;

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed self-checking bench for systolic_ctrl (N=4, DW=8, KW=8) with an
// operand-buffer model and a 4x4 output-stationary MAC array model.
module tb_systolic_ctrl;

    localparam int D = 10;  // drain length for N=4

    logic clk = 1'b0;
    logic rst_n;
    logic abort;

    int n_cmp = 0;
    int n_err = 0;

    systolic_ctrl_if #(.N(4), .DW(8), .KW(8)) bus ();

    systolic_ctrl #(
        .N (4),
        .DW(8),
        .KW(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
`ifdef SYSTOLIC_CTRL_ABORT_EN
        .abort(abort),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Operand buffers: one-cycle read latency, output held when not reading
    logic [31:0] a_mem [256];
    logic [31:0] b_mem [256];

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.a_rd_data <= '0;
            bus.b_rd_data <= '0;
        end else if (bus.rd_en) begin
            bus.a_rd_data <= a_mem[bus.rd_addr];
            bus.b_rd_data <= b_mem[bus.rd_addr];
        end
    end

    // Array model: a flows east, b flows south; product, accumulate, C_out stages
    logic [7:0]  ar  [4][4];
    logic [7:0]  br  [4][4];
    logic [15:0] pr  [4][4];
    logic [31:0] acc [4][4];
    logic [31:0] cm  [4][4];
    logic [31:0] exp_c [4][4];

    always @(posedge clk) begin
        logic [7:0] ain, bin;
        if (!bus.pe_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    ar[i][j] <= '0; br[i][j] <= '0; pr[i][j] <= '0;
                    acc[i][j] <= '0; cm[i][j] <= '0;
                end
            end
        end else if (bus.pe_en) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    if (j == 0) ain = bus.a_feed[i*8 +: 8];
                    else        ain = ar[i][j-1];
                    if (i == 0) bin = bus.b_feed[j*8 +: 8];
                    else        bin = br[i-1][j];
                    ar[i][j]  <= ain;
                    br[i][j]  <= bin;
                    pr[i][j]  <= ain * bin;
                    acc[i][j] <= acc[i][j] + 32'(pr[i][j]);
                    cm[i][j]  <= acc[i][j];
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {busy, done, rd_en, rd_addr, pe_en, pe_rst_n}
    function automatic logic [12:0] ctl();
        return {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.pe_en, bus.pe_rst_n};
    endfunction

    // Issues start in the current (IDLE) cycle and checks every cycle through the
    // IDLE cycle after done; returns in that IDLE cycle.
    task automatic run_txn(input int k, input bit chk_feed, input bit chk_c, input bit poke);
        int          last;
        logic [12:0] e;
        logic [7:0]  e_addr;
        logic [31:0] e_feed;
        bus.start = 1'b1;
        bus.k_len = k[7:0];
        step();
        bus.start = 1'b0;
        last = k + 3 + D;
        for (int c = 1; c <= last; c++) begin
            if (poke && c >= 2 && c <= k + 1) begin
                bus.start = 1'b1;
                bus.k_len = 8'd5;
            end else begin
                bus.start = 1'b0;
            end
            e_addr = (c >= 2 && c <= k + 1) ? 8'(c - 2) : 8'd0;
            e = {(c <= k + 2 + D), (c == k + 2 + D), (c >= 2 && c <= k + 1), e_addr,
                 (c >= 2 && c <= k + 1 + D), (c != 1)};
            check($sformatf("ctl_k%0d_c%0d", k, c), 64'(ctl()), 64'(e));
            if (chk_feed) begin
                e_feed = '0;
                for (int i = 0; i < 4; i++) begin
                    if (c == 3 + i) e_feed[i*8 +: 8] = 8'h11;
                end
                check($sformatf("a_feed_c%0d", c), 64'(bus.a_feed), 64'(e_feed));
                check($sformatf("b_feed_c%0d", c), 64'(bus.b_feed), 64'(e_feed));
            end
            if (chk_c && c == k + 2 + D) begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        check($sformatf("c_k%0d_%0d%0d", k, i, j), 64'(cm[i][j]),
                              64'(exp_c[i][j]));
                    end
                end
            end
            if (c != last) step();
        end
        bus.start = 1'b0;
    endtask

    localparam logic [12:0] CtlIdle = 13'b0_0_0_00000000_0_1;

    initial begin
        rst_n     = 1'b0;
        abort     = 1'b0;
        bus.start = 1'b0;
        bus.k_len = '0;
        for (int a = 0; a < 256; a++) begin
            a_mem[a] = '0;
            b_mem[a] = '0;
        end

        // Reset held for 3 cycles, then released
        repeat (3) step();
        check("rst_ctl", 64'(ctl()), 64'(0));
        check("rst_a_feed", 64'(bus.a_feed), 64'(0));
        check("rst_b_feed", 64'(bus.b_feed), 64'(0));
        rst_n = 1'b1;
        step();
        check("rst_release", 64'(ctl()), 64'(CtlIdle));

        // start with k_len=0 is ignored
        bus.start = 1'b1;
        bus.k_len = 8'd0;
        step();
        bus.start = 1'b0;
        check("klen0_a", 64'(ctl()), 64'(CtlIdle));
        step();
        check("klen0_b", 64'(ctl()), 64'(CtlIdle));

        // Skew: only k=0 carries 0x11 on every lane
        a_mem[0] = 32'h11111111;
        b_mem[0] = 32'h11111111;
        run_txn(3, 1'b1, 1'b0, 1'b0);

        // All-ones 4x4, k_len=4 -> every C = 4; start pulses in FEED must be ignored
        for (int a = 0; a < 4; a++) begin
            a_mem[a] = 32'h01010101;
            b_mem[a] = 32'h01010101;
        end
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) exp_c[i][j] = 32'd4;
        run_txn(4, 1'b0, 1'b1, 1'b1);
        step();
        check("no_queued_start", 64'(ctl()), 64'(CtlIdle));

        // Distinct lanes for k=0,1: A[i]=i+1, B[j]=j+1 -> C = 2(i+1)(j+1)
        a_mem[0] = 32'h04030201; b_mem[0] = 32'h04030201;
        a_mem[1] = 32'h04030201; b_mem[1] = 32'h04030201;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) exp_c[i][j] = 32'(2 * (i + 1) * (j + 1));
        run_txn(2, 1'b0, 1'b1, 1'b0);
        // Back-to-back: rows 2,3 still all-ones add 2 to each C
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) exp_c[i][j] = 32'(2 * (i + 1) * (j + 1) + 2);
        run_txn(4, 1'b0, 1'b1, 1'b0);

        // Maximum k_len: rd_addr must reach 254 without wrapping
        run_txn(255, 1'b0, 1'b0, 1'b0);

        // Reset in cycle 6 of a k_len=8 run
        bus.start = 1'b1;
        bus.k_len = 8'd8;
        step();
        bus.start = 1'b0;
        repeat (5) step();
        check("midrst_pre", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        step();
        check("midrst_ctl", 64'(ctl()), 64'(0));
        check("midrst_a_feed", 64'(bus.a_feed), 64'(0));
        rst_n = 1'b1;
        step();
        for (int c = 0; c < 20; c++) begin
            check($sformatf("midrst_idle_%0d", c), 64'(ctl()), 64'(CtlIdle));
            step();
        end
        run_txn(8, 1'b0, 1'b1, 1'b0);

`ifdef SYSTOLIC_CTRL_ABORT_EN
        // Abort in DRAIN (k_len=4: DRAIN begins in cycle 6) with operands in flight
        bus.start = 1'b1;
        bus.k_len = 8'd4;
        step();
        bus.start = 1'b0;
        repeat (5) step();
        check("abort_pre_pe_en", 64'(bus.pe_en), 64'(1));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_ctl", 64'(ctl()), 64'(13'b1_0_0_00000000_0_0));
        check("abort_a_feed", 64'(bus.a_feed), 64'(0));
        check("abort_b_feed", 64'(bus.b_feed), 64'(0));
        step();
        for (int c = 0; c < 16; c++) begin
            check($sformatf("abort_idle_%0d", c), 64'(ctl()), 64'(CtlIdle));
            step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_in_idle", 64'(ctl()), 64'(CtlIdle));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
